// File: rtl/cache_pkg.sv
// Shared refill-path types and AXI constants; the cache side reuses the line geometry.
// No logic here: enum, burst/size/resp encodings and line sizing only.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;

  localparam logic [1:0] BURST_INCR       = 2'b01;
  localparam logic [2:0] SIZE_4B          = 3'b010;
  localparam logic [1:0] RESP_OKAY        = 2'b00;
  localparam int         LINE_OFFSET_BITS = 5;
  localparam int         BLOCK_WIDTH      = 256;

endpackage

// File: rtl/refill_line_buffer.sv
// Beat-slot line register: one BEAT_W slot per beat, written at the counter index.
// Zero latency to the flat line output; no backpressure, a write is taken whenever wr_en is high.
module refill_line_buffer #(
  parameter int BEAT_W = 32,
  parameter int BEATS  = 8,
  parameter int IDX_W  = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [BEAT_W-1:0]       wr_dat,
  output logic [BEATS*BEAT_W-1:0] line_dat
);

  logic [BEATS-1:0][BEAT_W-1:0] slot_q, slot_d;

  // Unwritten slots keep their value, so a short burst leaves the previous line's tail in place.
  always_comb begin
    slot_d = slot_q;
    for (int k = 0; k < BEATS; k++) begin
      if (wr_en && (wr_idx == IDX_W'(k))) begin
        slot_d[k] = wr_dat;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign line_dat = slot_q;

endmodule

// File: rtl/icache_refill_unit.sv
// ICache line refill: one INCR burst per miss, beats packed into a line, one-cycle return pulse.
// Latency req->ret_valid is 10 cycles with no wait states; stalls on arready/rvalid, no queueing of rd_req.
module icache_refill_unit
  import cache_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         BEAT_W = 32,
  parameter int         BEATS  = 8,
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_rdy,
  output logic                    ret_valid,
  output logic                    ret_err,
  output logic [BEATS*BEAT_W-1:0] r_data,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_W-1:0]       araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [3:0]              arid,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [BEAT_W-1:0]       rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast
);

  localparam int LINE_W = BEATS * BEAT_W;
  localparam int OFS    = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(BEATS);

  refill_state_e     state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              beat_wr;
  logic              last_slot;

  // Offset bits are dropped by line alignment; the geometry compare only ties the package sizing in.
  logic unused_ok;
  assign unused_ok = ^{rd_addr[OFS-1:0], (LINE_W == BLOCK_WIDTH), (OFS == LINE_OFFSET_BITS)};

  assign last_slot = (cnt_q == IDX_W'(BEATS - 1));

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    beat_wr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          araddr_d = {rd_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (arready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rvalid) begin
          beat_wr = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (rresp != RESP_OKAY) begin
            err_d = 1'b1;
          end
          // Either end marker closes the line; disagreement between them is a length error.
          if (rlast || last_slot) begin
            state_d = ST_DONE;
            if (rlast != last_slot) begin
              err_d = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      araddr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  refill_line_buffer #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS),
    .IDX_W  (IDX_W)
  ) u_line_buf (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (beat_wr),
    .wr_idx   (cnt_q),
    .wr_dat   (rdata),
    .line_dat (r_data)
  );

  assign rd_rdy    = (state_q == ST_IDLE);
  assign arvalid   = (state_q == ST_ADDR);
  assign rready    = (state_q == ST_DATA);
  assign ret_valid = (state_q == ST_DONE);
  assign ret_err   = (state_q == ST_DONE) && err_q;
  assign araddr    = araddr_q;
  assign arlen     = 8'(BEATS - 1);
  assign arsize    = SIZE_4B;
  assign arburst   = BURST_INCR;
  assign arid      = AXI_ID;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed refill scenarios with a scoreboard: each request pushes its expected line/err/cycle,
// a monitor pops and compares on every ret_valid pulse.
module tb_icache_refill_unit;

  logic         clk = 1'b0;
  logic         rstn;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_err;
  logic [255:0] r_data;
  logic         arvalid;
  logic         arready;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [3:0]   arid;
  logic         rvalid;
  logic         rready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;

  typedef struct {
    logic [255:0] line;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  logic [255:0] exp_line;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  icache_refill_unit dut (
    .clk       (clk),
    .rstn      (rstn),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_err   (ret_err),
    .r_data    (r_data),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arid      (arid),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (rstn && ret_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ret_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ret_cycle", 256'(cyc), 256'(e.cyc));
        chk("ret_err", 256'(ret_err), 256'(e.err));
        chk("r_data", r_data, e.line);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic refill(input logic [31:0] addr, input int ar_wait, input logic [31:0] base,
                        input int err_beat, input int nbeats, input bit rlast_on_last,
                        input bit toggle, input int abort_at);
    exp_t        e;
    logic [31:0] exp_ar;
    int          gaps;
    exp_ar = addr & 32'hFFFF_FFE0;
    gaps   = toggle ? nbeats - 1 : 0;
    e.line = exp_line;
    for (int i = 0; i < nbeats; i++) e.line[i*32 +: 32] = base + 32'(i);
    e.err  = (err_beat >= 0 && err_beat < nbeats) || (nbeats != 8) || !rlast_on_last;
    e.cyc  = cyc + 2 + ar_wait + gaps + nbeats;
    if (abort_at < 0) begin
      exp_q.push_back(e);
      exp_line = e.line;
    end
    chk("rd_rdy_idle", 256'(rd_rdy), 256'(1));
    rd_req  = 1'b1;
    rd_addr = addr;
    @(posedge clk); #1;
    rd_req  = 1'b0;
    rd_addr = '0;
    for (int i = 0; i < ar_wait; i++) begin
      chk("arvalid_stall", 256'(arvalid), 256'(1));
      chk("araddr_stall", 256'(araddr), 256'(exp_ar));
      chk("rd_rdy_busy", 256'(rd_rdy), 256'(0));
      @(posedge clk); #1;
    end
    chk("arvalid", 256'(arvalid), 256'(1));
    chk("araddr", 256'(araddr), 256'(exp_ar));
    chk("ar_const", 256'({arlen, arsize, arburst, arid}), 256'({8'd7, 3'b010, 2'b01, 4'h0}));
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    chk("arvalid_drop", 256'(arvalid), 256'(0));
    for (int i = 0; i < nbeats; i++) begin
      if (toggle && i > 0) begin
        rvalid = 1'b0;
        @(posedge clk); #1;
      end
      rvalid = 1'b1;
      rdata  = base + 32'(i);
      rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      rlast  = rlast_on_last && (i == nbeats - 1);
      chk("rready", 256'(rready), 256'(1));
      if (i == abort_at) begin
        #3 rstn = 1'b0;
        #1;
        chk("rst_async_outs", 256'({rd_rdy, ret_valid, ret_err, arvalid, rready}), 256'(5'b10000));
        chk("rst_async_araddr", 256'(araddr), 256'(0));
        chk("rst_async_rdata", r_data, 256'(0));
        rvalid   = 1'b0;
        rlast    = 1'b0;
        rresp    = 2'b00;
        exp_line = '0;
        @(posedge clk); #1;
        rstn = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("ret_valid_pulse", 256'(ret_valid), 256'(0));
    chk("r_data_hold", r_data, exp_line);
  endtask

  initial begin
    rstn     = 1'b0;
    rd_req   = 1'b0;
    rd_addr  = '0;
    arready  = 1'b0;
    rvalid   = 1'b0;
    rdata    = '0;
    rresp    = 2'b00;
    rlast    = 1'b0;
    exp_line = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 256'({rd_rdy, ret_valid, ret_err, arvalid, rready}), 256'(5'b10000));
    chk("reset_araddr", 256'(araddr), 256'(0));
    chk("reset_rdata", r_data, 256'(0));
    chk("reset_const", 256'({arlen, arsize, arburst, arid}), 256'({8'd7, 3'b010, 2'b01, 4'h0}));
    rstn = 1'b1;
    @(posedge clk); #1;

    refill(32'h1C00_0034, 0, 32'hA0, -1, 8, 1'b1, 1'b0, -1);  // basic
    chk("basic_beat0", 256'(r_data[31:0]), 256'(32'hA0));
    chk("basic_beat7", 256'(r_data[255:224]), 256'(32'hA7));
    refill(32'h2000_0104, 5, 32'hB0, -1, 8, 1'b1, 1'b0, -1);  // arready stalled 5 cycles
    refill(32'h3000_0040, 0, 32'hC0, -1, 8, 1'b1, 1'b1, -1);  // rvalid toggling
    refill(32'h4000_001F, 0, 32'hD0,  3, 8, 1'b1, 1'b0, -1);  // SLVERR on beat 3
    refill(32'h5000_0060, 1, 32'hE0, -1, 5, 1'b1, 1'b0, -1);  // early rlast on beat 4
    chk("early_tail_kept", 256'(r_data[255:160]), 256'({32'hD7, 32'hD6, 32'hD5}));
    refill(32'h6000_0000, 0, 32'hF0, -1, 8, 1'b0, 1'b0, -1);  // rlast missing
    refill(32'h7000_0080, 0, 32'h10, -1, 8, 1'b1, 1'b0,  2);  // reset during beat 2
    refill(32'h7000_0080, 0, 32'h20, -1, 8, 1'b1, 1'b0, -1);  // clean refill after reset

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
